cacheline_adapter: RTL
======================

# cacheline_adapter

Sits directly below the 4-way set-associative cache on its downward facing port. Converts each single 256-bit line read or write into a 4-beat, 64-bit burst on the banked burst memory. One request is outstanding at a time. Returns a one-cycle `dfp_resp` with the assembled line for reads, or the completion for writes.

## Interface
Parameters:
- `LINE_W`, default 256, cache line width in bits.
- `BEAT_W`, default 64, memory beat width in bits. Beats per line `BEATS = LINE_W/BEAT_W = 4`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `dfp_addr`  in  32  line address from the cache; bits [4:0] are ignored.
- `dfp_read`  in  1  line read request, held by the cache until `dfp_resp`.
- `dfp_write`  in  1  line write request, held by the cache until `dfp_resp`.
- `dfp_wdata`  in  256  line to write.
- `dfp_rdata`  out  256  assembled read line.
- `dfp_resp`  out  1  one-cycle completion pulse.
- `bmem_addr`  out  32  burst address, always 32-byte aligned.
- `bmem_read`  out  1  burst read command, one cycle.
- `bmem_write`  out  1  write beat valid.
- `bmem_wdata`  out  64  write beat data.
- `bmem_ready`  in  1  memory accepts a command or beat this cycle.
- `bmem_raddr`  in  32  address tag of the returning beat.
- `bmem_rdata`  in  64  returning read beat.
- `bmem_rvalid`  in  1  returning beat valid.

## Operation
- FSM states: IDLE, RD_REQ, RD_DATA, WR_BURST, RESP, COOL.
- **IDLE**
  - On `dfp_write`, latch `{dfp_addr[31:5],5'b0}` and `dfp_wdata`, then go to WR_BURST.
  - Otherwise on `dfp_read`, latch the address, then go to RD_REQ.
  - Write wins if both are high. Both high is illegal for the cache but must not hang the adapter.
- **RD_REQ**
  - Drive `bmem_read=1` and `bmem_addr` = latched address.
  - When `bmem_ready`, go to RD_DATA with `beat=0`.
  - Hold the command while `!bmem_ready`.
- **RD_DATA**
  - On `bmem_rvalid && bmem_raddr==latched addr`: write `bmem_rdata` into line bits `[beat*64 +: 64]` and increment `beat`.
  - Beat 0 maps to bits [63:0].
  - Drop beats whose address does not match.
  - After beat 3 is accepted, go to RESP.
- **WR_BURST**
  - Drive `bmem_write=1`, `bmem_addr` = latched address (constant for all beats), and `bmem_wdata` = latched line `[beat*64 +: 64]`.
  - `beat` advances only on `bmem_ready`.
  - After beat 3 is accepted, go to RESP.
- **RESP**
  - `dfp_resp=1` for exactly one cycle, then go to COOL.
- **COOL**
  - Ignore `dfp_read` and `dfp_write` for one cycle. This covers the cache's registered response, since it drops its request one cycle late.
  - Then go to IDLE.
- `dfp_rdata` is registered. It holds the last completed read line until the next read completes. It is not altered by writes.
- `bmem_rvalid` outside RD_DATA is ignored.
- `beat` is 2 bits and is never reused across requests; it is cleared on entry to RD_DATA and WR_BURST.

## Timing
- Reset: state=IDLE, `beat=0`, `dfp_resp=0`, `dfp_rdata=0`, `bmem_read=0`, `bmem_write=0`, `bmem_addr=0`, `bmem_wdata=0`.
- All outputs are driven from registers or from the state decode only. There is no combinational path from `bmem_*` inputs to `dfp_*` outputs.
- Read latency, from the IDLE cycle that sees `dfp_read` to `dfp_resp`: 1 cycle, plus the RD_REQ cycles until ready, plus the memory latency, plus 4 beat cycles, plus 1.
- Write latency: 1 cycle, plus 4 accepted-beat cycles, plus stall cycles, plus 1.
- Back-to-back requests have a minimum gap of 2 cycles (RESP and COOL) between completion and the next acceptance.
- `rst` mid-operation:
  - Returns to IDLE the next edge. No `dfp_resp` is issued for the aborted request.
  - A partial write burst is abandoned.
  - Late read beats are dropped because the state is not RD_DATA.

## Structure
- In the `cache_types` package:
  - `adapter_state_t` enum with the six states.
  - `localparam BEATS = 4`.
  - `LINE_OFFSET_BITS = 5`.
- Single module. No sub-module is needed. The beat counter and line shift buffer are inline.

## Test plan
- **Read, zero stall:** `dfp_read`, `dfp_addr=0x0000_1234`.
  - Expect `bmem_read` for 1 cycle with `bmem_addr=0x0000_1220`.
  - Return beats `0x11..`, `0x22..`, `0x33..`, `0x44..`.
  - Expect `dfp_rdata` = `{0x44..,0x33..,0x22..,0x11..}` and `dfp_resp` high for exactly 1 cycle.
- **Write with stalls:** `dfp_wdata = {D3,D2,D1,D0}`, `bmem_ready` low on alternate cycles.
  - Expect D0..D3 each presented in order and held while stalled.
  - Expect `bmem_addr` constant, and `dfp_resp` 1 cycle after D3 is accepted.
- **Mismatched beat:** inject one `bmem_rvalid` with `bmem_raddr=0xDEAD_0000` mid-burst.
  - Expect it dropped. The line is assembled from the 4 matching beats only.
- **Held request after resp:** cache holds `dfp_read` 1 cycle past `dfp_resp`.
  - Expect no second `bmem_read`. The next read is accepted only after COOL.
- **Reset mid-read:** assert `rst` after beat 1.
  - Expect all outputs 0 next cycle and no `dfp_resp`.
  - The remaining beats are ignored. A following read completes correctly.
- **Simultaneous read and write:** both high in IDLE.
  - Expect a write burst first, with `bmem_read` never asserted.

Source files
------------

// File: rtl/cacheline_adapter_pkg.sv
// Shared types and constants for the cache / burst-memory adapter.
package cache_types;

  localparam int BEATS            = 4;
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_BURST,
    RESP,
    COOL
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one cache-line read/write into a multi-beat burst on the
// banked burst memory. One request in flight; every output is a register.
module cacheline_adapter
  import cache_types::*;
#(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [31:0]   ADDR_MASK = ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);

  adapter_state_t                  r_state;
  logic [BW-1:0]                   r_beat;
  logic [NBEATS-1:0][BEAT_W-1:0]   r_wline;
  logic [NBEATS-1:0][BEAT_W-1:0]   r_rbuf;

  logic [NBEATS-1:0][BEAT_W-1:0]   w_wbeats;
  logic [NBEATS-1:0][BEAT_W-1:0]   w_rline;
  logic                            w_beat_hit;

  assign w_wbeats = dfp_wdata;

  // bmem_addr holds the latched line address for the whole request, so it
  // doubles as the tag that returning beats must match.
  assign w_beat_hit = bmem_rvalid && (bmem_raddr == bmem_addr);

  // Read line as it will look once the current beat is merged in; used to
  // publish the finished line in the same edge that accepts the last beat.
  always_comb begin
    w_rline         = r_rbuf;
    w_rline[r_beat] = bmem_rdata;
  end

  // Request FSM: outputs are computed for the next state and registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_wline    <= '0;
      r_rbuf     <= '0;
      dfp_rdata  <= '0;
      dfp_resp   <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Write takes priority so an illegal read+write still completes.
          if (dfp_write) begin
            bmem_addr  <= dfp_addr & ADDR_MASK;
            r_wline    <= w_wbeats;
            bmem_wdata <= w_wbeats[0];
            bmem_write <= 1'b1;
            r_beat     <= '0;
            r_state    <= WR_BURST;
          end else if (dfp_read) begin
            bmem_addr <= dfp_addr & ADDR_MASK;
            bmem_read <= 1'b1;
            r_state   <= RD_REQ;
          end
        end

        RD_REQ: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            r_beat    <= '0;
            r_state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          // Beats tagged with a foreign address are silently dropped.
          if (w_beat_hit) begin
            r_rbuf[r_beat] <= bmem_rdata;
            r_beat         <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) begin
              dfp_rdata <= w_rline;
              dfp_resp  <= 1'b1;
              r_state   <= RESP;
            end
          end
        end

        WR_BURST: begin
          // Current beat stays on the bus until memory takes it.
          if (bmem_ready) begin
            if (r_beat == LAST_BEAT) begin
              bmem_write <= 1'b0;
              dfp_resp   <= 1'b1;
              r_state    <= RESP;
            end else begin
              r_beat     <= r_beat + 1'b1;
              bmem_wdata <= r_wline[r_beat + 1'b1];
            end
          end
        end

        RESP: begin
          dfp_resp <= 1'b0;
          r_state  <= COOL;
        end

        // The cache drops its request a cycle after seeing resp; skip that cycle.
        COOL: r_state <= IDLE;

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
